// File: rtl/register_file.sv
// Datapath register file: two combinational read ports and one write port.
// Writes go through a one-entry write-back latch that reads bypass from.
module register_file #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  output logic                  wbPending
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam bit HARD_ZERO = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  wbValid;
  logic [ADDR_WIDTH-1:0] wbReg;
  logic [DATA_WIDTH-1:0] wbData;
  logic                  writeAccepted;

  // A write aimed at the hard-wired zero register never enters the latch.
  assign writeAccepted = regWrite && !(HARD_ZERO && (writeReg == '0));

  // NOTE: sequential state uses non-blocking assignments so that the commit
  // below reads the latch contents from before this edge's capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbValid <= 1'b0;
      wbReg   <= '0;
      wbData  <= '0;
      // NOTE: the array is reset because every register must read zero after
      // reset; this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wbValid) begin
        regs[wbReg] <= wbData;
      end
      wbValid <= writeAccepted;
      wbReg   <= writeReg;
      wbData  <= writeData;
    end
  end

  // NOTE: each output gets a default first so no path leaves it unassigned
  // (no inferred latch); later assignments take priority.
  always_comb begin
    readData1 = regs[readReg1];
    if (wbValid && (wbReg == readReg1)) begin
      readData1 = wbData;
    end
    if (HARD_ZERO && (readReg1 == '0)) begin
      readData1 = '0;
    end
  end

  always_comb begin
    readData2 = regs[readReg2];
    if (wbValid && (wbReg == readReg2)) begin
      readData2 = wbData;
    end
    if (HARD_ZERO && (readReg2 == '0)) begin
      readData2 = '0;
    end
  end

  assign wbPending = wbValid;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: per-cycle vectors with expected read
// data pushed to a scoreboard at drive time and compared mid-cycle.
module tb_register_file;

  logic       clk;
  logic       reset;
  logic [1:0] readReg1;
  logic [1:0] readReg2;
  logic       regWrite;
  logic [1:0] writeReg;
  logic [7:0] writeData;
  logic [7:0] readData1;
  logic [7:0] readData2;
  logic       wbPending;
  logic [7:0] zReadData1;
  logic [7:0] zReadData2;
  logic       zWbPending;

  register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .ZERO_REG(0)) dut (
    .clk(clk), .reset(reset),
    .readReg1(readReg1), .readReg2(readReg2),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .readData1(readData1), .readData2(readData2), .wbPending(wbPending)
  );

  register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .ZERO_REG(1)) dutZ (
    .clk(clk), .reset(reset),
    .readReg1(readReg1), .readReg2(readReg2),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .readData1(zReadData1), .readData2(zReadData2), .wbPending(zWbPending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [1:0] wReg;
    logic [7:0] wData;
    logic [1:0] r1;
    logic [1:0] r2;
    logic [7:0] e1;
    logic [7:0] e2;
    logic       ePend;
  } vec_t;

  typedef struct {
    logic [7:0] e1;
    logic [7:0] e2;
    logic       ePend;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] wReg, input logic [7:0] wData,
                              input logic [1:0] r1, input logic [1:0] r2,
                              input logic [7:0] e1, input logic [7:0] e2, input logic ePend);
    vec_t v;
    v.wr = wr; v.wReg = wReg; v.wData = wData; v.r1 = r1; v.r2 = r2;
    v.e1 = e1; v.e2 = e2; v.ePend = ePend;
    return v;
  endfunction

  // One clock cycle: drive just after the rising edge, compare at the falling edge.
  task automatic stepVec(input vec_t v, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    regWrite  = v.wr;
    writeReg  = v.wReg;
    writeData = v.wData;
    readReg1  = v.r1;
    readReg2  = v.r2;
    sb.push_back('{v.e1, v.e2, v.ePend, name});
    @(negedge clk);
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check({e.name, ".rd1"}, readData1, e.e1);
      check({e.name, ".rd2"}, readData2, e.e2);
      check({e.name, ".pend"}, {7'b0, wbPending}, {7'b0, e.ePend});
    end
  endtask

  vec_t       tbl[15];
  logic [7:0] addedData;

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; regWrite = 1'b0; writeReg = '0; writeData = '0;
    readReg1 = '0; readReg2 = '0;

    // r2 write latency, r1 back-to-back, then four consecutive writes.
    tbl[0]  = mk(1, 2, 8'hA5, 2, 0, 8'h00, 8'h00, 0);
    tbl[1]  = mk(0, 0, 8'h00, 2, 2, 8'hA5, 8'hA5, 1);
    tbl[2]  = mk(0, 0, 8'h00, 2, 0, 8'hA5, 8'h00, 0);
    tbl[3]  = mk(1, 1, 8'h11, 1, 1, 8'h00, 8'h00, 0);
    tbl[4]  = mk(1, 1, 8'h22, 1, 1, 8'h11, 8'h11, 1);
    tbl[5]  = mk(0, 0, 8'h00, 1, 1, 8'h22, 8'h22, 1);
    tbl[6]  = mk(0, 0, 8'h00, 1, 1, 8'h22, 8'h22, 0);
    tbl[7]  = mk(1, 0, 8'h0F, 0, 3, 8'h00, 8'h00, 0);
    tbl[8]  = mk(1, 1, 8'hF0, 0, 1, 8'h0F, 8'h22, 1);
    tbl[9]  = mk(1, 2, 8'h80, 1, 0, 8'hF0, 8'h0F, 1);
    tbl[10] = mk(1, 3, 8'h7F, 2, 3, 8'h80, 8'h00, 1);
    tbl[11] = mk(0, 0, 8'h00, 3, 2, 8'h7F, 8'h80, 1);
    tbl[12] = mk(0, 0, 8'h00, 0, 1, 8'h0F, 8'hF0, 0);
    tbl[13] = mk(0, 0, 8'h00, 2, 3, 8'h80, 8'h7F, 0);
    tbl[14] = mk(0, 0, 8'h00, 3, 0, 8'h7F, 8'h0F, 0);

    // Reset state, checked on every register through both ports.
    #12;
    for (int r = 0; r < 4; r++) begin
      readReg1 = 2'(r); readReg2 = 2'(3 - r);
      #1;
      check($sformatf("reset.rd1.r%0d", r), readData1, 8'h00);
      check($sformatf("reset.rd2.r%0d", 3 - r), readData2, 8'h00);
    end
    check("reset.pend", {7'b0, wbPending}, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      stepVec(tbl[i], $sformatf("vec%0d", i));
    end

    // Writing r0 = 0xFF: ordinary register vs hard-wired zero.
    stepVec(mk(1, 0, 8'hFF, 0, 3, 8'h0F, 8'h7F, 0), "zero.wr");
    check("zero.wr.z_rd1", zReadData1, 8'h00);
    check("zero.wr.z_pend", {7'b0, zWbPending}, 8'h00);
    stepVec(mk(0, 0, 8'h00, 0, 0, 8'hFF, 8'hFF, 1), "zero.rd");
    check("zero.rd.z_rd1", zReadData1, 8'h00);
    check("zero.rd.z_pend", {7'b0, zWbPending}, 8'h00);

    // ALU write-back: 0x7F + 0x01 into r3.
    stepVec(mk(1, 0, 8'h01, 3, 3, 8'h7F, 8'h7F, 0), "alu.setup");
    stepVec(mk(0, 0, 8'h00, 3, 0, 8'h7F, 8'h01, 1), "alu.ops");
    addedData = readData1 + readData2;
    stepVec(mk(1, 3, addedData, 3, 0, 8'h7F, 8'h01, 0), "alu.wb");
    stepVec(mk(0, 0, 8'h00, 3, 3, 8'h80, 8'h80, 1), "alu.result");

    // ALU wrap: 0xFF + 0x01 stored as 0x00.
    stepVec(mk(1, 2, 8'hFF, 2, 0, 8'h80, 8'h01, 0), "wrap.setup");
    stepVec(mk(0, 0, 8'h00, 2, 0, 8'hFF, 8'h01, 1), "wrap.ops");
    addedData = readData1 + readData2;
    stepVec(mk(1, 3, addedData, 3, 2, 8'h80, 8'hFF, 0), "wrap.wb");
    stepVec(mk(0, 0, 8'h00, 3, 3, 8'h00, 8'h00, 1), "wrap.result");
    stepVec(mk(0, 0, 8'h00, 3, 3, 8'h00, 8'h00, 0), "wrap.array");

    // Reset mid-run with a write still in the latch.
    stepVec(mk(1, 1, 8'h55, 1, 1, 8'hF0, 8'hF0, 0), "midrst.wr");
    @(posedge clk);
    #1;
    regWrite = 1'b0;
    #2;
    reset = 1'b1;
    for (int r = 0; r < 4; r++) begin
      readReg1 = 2'(r); readReg2 = 2'(r);
      #1;
      check($sformatf("midrst.rd1.r%0d", r), readData1, 8'h00);
      check($sformatf("midrst.rd2.r%0d", r), readData2, 8'h00);
    end
    check("midrst.pend", {7'b0, wbPending}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    stepVec(mk(0, 0, 8'h00, 1, 2, 8'h00, 8'h00, 0), "postrst.a");
    stepVec(mk(0, 0, 8'h00, 3, 1, 8'h00, 8'h00, 0), "postrst.b");

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard.leftover actual=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
